axi_read_bus_rr: RTL

- Parametrised N-master to 1-slave AXI3 read-channel interconnect for the cache/uncached load path.
- Replaces the fixed three-master load bus.
- One-hot grant is held for a full transaction: AR handshake through the last R beat.
- Adds selectable round-robin or fixed-priority arbitration, configurable widths and master count, and an R-channel protocol checker (beat count and ID match).

---
 rtl/axi_read_bus_rr_pkg.sv | 21 ++
 rtl/axi_read_bus_rr_arbiter.sv | 35 +++
 rtl/axi_read_bus_rr.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/axi_read_bus_rr_pkg.sv
// Shared constants for the N-to-1 AXI3 read interconnect: state encoding,
// AXI field widths and arbitration mode selectors.
package axi_read_bus_rr_pkg;

    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned LOCK_W  = 2;
    localparam int unsigned CACHE_W = 4;
    localparam int unsigned PROT_W  = 3;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned CNT_W   = LEN_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam bit ARB_FIXED = 1'b0;
    localparam bit ARB_RR    = 1'b1;

endpackage

// File: rtl/axi_read_bus_rr_arbiter.sv
// One-hot winner select: round-robin starting after ptr, or lowest index first.
module axi_read_bus_rr_arbiter
    import axi_read_bus_rr_pkg::*;
#(
    parameter int unsigned NUM_M = 3,
    parameter int unsigned IDX_W = $clog2(NUM_M),
    parameter bit          RR_EN = ARB_RR
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_M-1:0] winner_c,
    output logic [IDX_W-1:0] winner_idx_c
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan candidates in priority order; first requester wins.
    always_comb begin
        winner_c     = '0;
        winner_idx_c = '0;
        found        = 1'b0;
        cand         = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (RR_EN) cand = IDX_W'((32'(ptr) + 32'd1 + k) % NUM_M);
            else       cand = IDX_W'(k);
            if (!found && req[cand]) begin
                found          = 1'b1;
                winner_c[cand] = 1'b1;
                winner_idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_read_bus_rr.sv
// N-master to 1-slave AXI3 read interconnect; grant held from AR handshake
// through the last R beat, with an R-channel beat-count/ID checker.
module axi_read_bus_rr
    import axi_read_bus_rr_pkg::*;
#(
    parameter int unsigned NUM_M  = 3,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR_EN  = ARB_RR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      busy,
    output logic                      proto_err,
    output logic [ID_W-1:0]           arid,
    output logic [ADDR_W-1:0]         araddr,
    output logic [LEN_W-1:0]          arlen,
    output logic [SIZE_W-1:0]         arsize,
    output logic [BURST_W-1:0]        arburst,
    output logic [LOCK_W-1:0]         arlock,
    output logic [CACHE_W-1:0]        arcache,
    output logic [PROT_W-1:0]         arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [ID_W-1:0]           rid,
    input  logic [DATA_W-1:0]         rdata,
    input  logic [RESP_W-1:0]         rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [NUM_M-1:0]          m_req,
    output logic [NUM_M-1:0]          m_grnt,
    input  logic [NUM_M*ID_W-1:0]     m_arid,
    input  logic [NUM_M*ADDR_W-1:0]   m_araddr,
    input  logic [NUM_M*LEN_W-1:0]    m_arlen,
    input  logic [NUM_M*SIZE_W-1:0]   m_arsize,
    input  logic [NUM_M*BURST_W-1:0]  m_arburst,
    input  logic [NUM_M*LOCK_W-1:0]   m_arlock,
    input  logic [NUM_M*CACHE_W-1:0]  m_arcache,
    input  logic [NUM_M*PROT_W-1:0]   m_arprot,
    input  logic [NUM_M-1:0]          m_arvalid,
    output logic [NUM_M-1:0]          m_arready,
    output logic [NUM_M*ID_W-1:0]     m_rid,
    output logic [NUM_M*DATA_W-1:0]   m_rdata,
    output logic [NUM_M*RESP_W-1:0]   m_rresp,
    output logic [NUM_M-1:0]          m_rlast,
    output logic [NUM_M-1:0]          m_rvalid,
    input  logic [NUM_M-1:0]          m_rready
);

    localparam int unsigned IDX_W = $clog2(NUM_M);

    logic [1:0]         state, state_nxt;
    logic [IDX_W-1:0]   gnt_idx, rr_ptr, winner_idx_c;
    logic [NUM_M-1:0]   winner_c, ar_sel, r_sel;
    logic [CNT_W-1:0]   beat_cnt, cnt_nxt, len_p1;
    logic [ID_W-1:0]    cap_id;
    logic [LEN_W-1:0]   cap_len;
    logic               beat, beat_err, ar_hs;

    logic [ID_W-1:0]    s_arid    [NUM_M];
    logic [ADDR_W-1:0]  s_araddr  [NUM_M];
    logic [LEN_W-1:0]   s_arlen   [NUM_M];
    logic [SIZE_W-1:0]  s_arsize  [NUM_M];
    logic [BURST_W-1:0] s_arburst [NUM_M];
    logic [LOCK_W-1:0]  s_arlock  [NUM_M];
    logic [CACHE_W-1:0] s_arcache [NUM_M];
    logic [PROT_W-1:0]  s_arprot  [NUM_M];

    axi_read_bus_rr_arbiter #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W),
        .RR_EN (RR_EN)
    ) u_arb (
        .req          (m_req),
        .ptr          (rr_ptr),
        .winner_c     (winner_c),
        .winner_idx_c (winner_idx_c)
    );

    assign ar_sel = m_grnt & {NUM_M{state == ST_ADDR}};
    assign r_sel  = m_grnt & {NUM_M{state == ST_DATA}};

    // Per-master slices: unpack AR requests, gate R responses to the owner only.
    for (genvar i = 0; i < NUM_M; i++) begin : g_slice
        assign s_arid[i]    = m_arid[i*ID_W +: ID_W];
        assign s_araddr[i]  = m_araddr[i*ADDR_W +: ADDR_W];
        assign s_arlen[i]   = m_arlen[i*LEN_W +: LEN_W];
        assign s_arsize[i]  = m_arsize[i*SIZE_W +: SIZE_W];
        assign s_arburst[i] = m_arburst[i*BURST_W +: BURST_W];
        assign s_arlock[i]  = m_arlock[i*LOCK_W +: LOCK_W];
        assign s_arcache[i] = m_arcache[i*CACHE_W +: CACHE_W];
        assign s_arprot[i]  = m_arprot[i*PROT_W +: PROT_W];

        assign m_rid[i*ID_W +: ID_W]         = r_sel[i] ? rid   : '0;
        assign m_rdata[i*DATA_W +: DATA_W]   = r_sel[i] ? rdata : '0;
        assign m_rresp[i*RESP_W +: RESP_W]   = r_sel[i] ? rresp : '0;
        assign m_rlast[i]                    = r_sel[i] & rlast;
        assign m_rvalid[i]                   = r_sel[i] & rvalid;
    end

    assign m_arready = ar_sel & {NUM_M{arready}};

    always_comb begin
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        arlock  = '0;
        arcache = '0;
        arprot  = '0;
        arvalid = 1'b0;
        if (state == ST_ADDR) begin
            arid    = s_arid[gnt_idx];
            araddr  = s_araddr[gnt_idx];
            arlen   = s_arlen[gnt_idx];
            arsize  = s_arsize[gnt_idx];
            arburst = s_arburst[gnt_idx];
            arlock  = s_arlock[gnt_idx];
            arcache = s_arcache[gnt_idx];
            arprot  = s_arprot[gnt_idx];
            arvalid = m_arvalid[gnt_idx];
        end
    end

    assign rready   = (state == ST_DATA) & m_rready[gnt_idx];
    assign busy     = (state != ST_IDLE);
    assign ar_hs    = arvalid & arready;
    assign beat     = (state == ST_DATA) & rvalid & rready;
    assign cnt_nxt  = beat_cnt + CNT_W'(1);
    assign len_p1   = CNT_W'(cap_len) + CNT_W'(1);
    // Wrong ID, or rlast disagreeing with whether this is the final beat.
    assign beat_err = (rid != cap_id) | (rlast != (cnt_nxt == len_p1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // An accepted AR wins over a same-cycle request drop: the slave owes us data.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|m_req) state_nxt = ST_ADDR;
            ST_ADDR: begin
                if (ar_hs)                 state_nxt = ST_DATA;
                else if (!m_req[gnt_idx])  state_nxt = ST_IDLE;
            end
            ST_DATA: if (beat && rlast) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_grnt    <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= IDX_W'(NUM_M - 1);
            beat_cnt  <= '0;
            cap_id    <= '0;
            cap_len   <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= beat & beat_err;
            if (state == ST_IDLE && state_nxt == ST_ADDR) begin
                m_grnt  <= winner_c;
                gnt_idx <= winner_idx_c;
            end else if (state != ST_IDLE && state_nxt == ST_IDLE) begin
                m_grnt  <= '0;
            end
            if (state == ST_ADDR && ar_hs) begin
                cap_id   <= arid;
                cap_len  <= arlen;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= cnt_nxt;
            end
            if (RR_EN && beat && rlast) rr_ptr <= gnt_idx;
        end
    end

endmodule
